// File: rtl/trap_filter_pv.sv
// Parametrised trapezoidal (Jordanov) shaper with input/output valid, priming suppression and clear.
// Optional output clamping is enabled by defining TRAP_FILTER_SAT_EN.
module trap_filter_pv #(
    parameter int          ADC_W     = 16,
    parameter int          K         = 10,
    parameter int          L         = 6,
    parameter int unsigned M         = 16,
    parameter int          ACC_W     = 40,
    parameter int          OUT_SHIFT = 4,
    parameter int          OUT_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    in_valid,
    input  logic [ADC_W-1:0]        input_data,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] output_data,
    output logic                    sat
);

    if (K < 1 || L < 1) begin : g_param_check
        $error("trap_filter_pv: K and L must both be >= 1");
    end

    localparam int DEPTH = K + L + 1;
    localparam int CNT_W = $clog2(K + L + 1);
    localparam logic [CNT_W-1:0] PRIME_N = CNT_W'(K + L);
    localparam logic signed [ACC_W-1:0] M_S = ACC_W'(M);
`ifdef TRAP_FILTER_SAT_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;
`endif

    // dly_q[0] holds the newest accepted sample, dly_q[i] the sample i acceptances back
    logic [ADC_W-1:0]        dly_q [DEPTH];
    logic [ADC_W-1:0]        dly_d [DEPTH];
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4:0]              vld_q, vld_d;
    logic [4:0]              prm_q, prm_d;
    logic signed [ACC_W-1:0] d_q, d_d;
    logic signed [ACC_W-1:0] p_q, p_d;
    logic signed [ACC_W-1:0] md_q, md_d;
    logic signed [ACC_W-1:0] r_q, r_d;
    logic signed [ACC_W-1:0] s_q, s_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] output_data_q, output_data_d;
    logic                    sat_q, sat_d;
`ifdef TRAP_FILTER_SAT_EN
    logic signed [ACC_W-1:0] y;
`endif

    function automatic logic signed [ACC_W-1:0] ext(input logic [ADC_W-1:0] x);
        return signed'(ACC_W'(x));
    endfunction

    always_comb begin
        for (int i = 0; i < DEPTH; i++) dly_d[i] = dly_q[i];
        cnt_d         = cnt_q;
        vld_d         = {vld_q[3:0], 1'b0};
        prm_d         = {prm_q[3:0], 1'b0};
        d_d           = ext(dly_q[0]) - ext(dly_q[K]) - ext(dly_q[L]) + ext(dly_q[K+L]);
        p_d           = vld_q[1] ? p_q + d_q : p_q;
        md_d          = d_q * M_S;
        r_d           = p_q + md_q;
        s_d           = vld_q[3] ? s_q + r_q : s_q;
        out_valid_d   = vld_q[4] & prm_q[4];
        output_data_d = output_data_q;
        sat_d         = sat_q;
`ifdef TRAP_FILTER_SAT_EN
        y = s_q >>> OUT_SHIFT;
`endif

        if (in_valid) begin
            dly_d[0] = input_data;
            for (int i = 1; i < DEPTH; i++) dly_d[i] = dly_q[i-1];
            vld_d[0] = 1'b1;
            prm_d[0] = (cnt_q == PRIME_N);
            if (cnt_q != PRIME_N) cnt_d = cnt_q + 1'b1;
        end

        // Output regs follow every stage-5 sample, primed or not; out_valid is the qualifier
        if (vld_q[4]) begin
`ifdef TRAP_FILTER_SAT_EN
            if (y > Y_MAX) begin
                output_data_d = Y_MAX[OUT_W-1:0];
                sat_d         = 1'b1;
            end else if (y < Y_MIN) begin
                output_data_d = Y_MIN[OUT_W-1:0];
                sat_d         = 1'b1;
            end else begin
                output_data_d = y[OUT_W-1:0];
                sat_d         = 1'b0;
            end
`else
            output_data_d = OUT_W'(s_q >>> OUT_SHIFT);
            sat_d         = 1'b0;
`endif
        end

        if (clr) begin
            for (int i = 0; i < DEPTH; i++) dly_d[i] = '0;
            cnt_d         = '0;
            vld_d         = '0;
            prm_d         = '0;
            d_d           = '0;
            p_d           = '0;
            md_d          = '0;
            r_d           = '0;
            s_d           = '0;
            out_valid_d   = 1'b0;
            output_data_d = '0;
            sat_d         = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) dly_q[i] <= '0;
            cnt_q         <= '0;
            vld_q         <= '0;
            prm_q         <= '0;
            d_q           <= '0;
            p_q           <= '0;
            md_q          <= '0;
            r_q           <= '0;
            s_q           <= '0;
            out_valid_q   <= 1'b0;
            output_data_q <= '0;
            sat_q         <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) dly_q[i] <= dly_d[i];
            cnt_q         <= cnt_d;
            vld_q         <= vld_d;
            prm_q         <= prm_d;
            d_q           <= d_d;
            p_q           <= p_d;
            md_q          <= md_d;
            r_q           <= r_d;
            s_q           <= s_d;
            out_valid_q   <= out_valid_d;
            output_data_q <= output_data_d;
            sat_q         <= sat_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign output_data = output_data_q;
    assign sat         = sat_q;

endmodule
